// File: rtl/nearest_block_resolver_if.sv
// Stream bundle for nearest_block_resolver: per-block beats in, one resolved pixel out.
// slave is the resolver side; master is the upstream/downstream side that drives it.
interface nearest_block_resolver_if #(
    parameter int X_W     = 11,
    parameter int Y_W     = 10,
    parameter int INDEX_W = 4
);
    logic               valid_in;
    logic               ready_out;
    logic [X_W-1:0]     x_in;
    logic [Y_W-1:0]     y_in;
    logic [INDEX_W-1:0] block_index_in;
    logic               intersect_in;
    logic [31:0]        t_in;
    logic [31:0]        ray_x_in;
    logic [31:0]        ray_y_in;
    logic [31:0]        ray_z_in;

    logic               valid_out;
    logic               ready_in;
    logic [X_W-1:0]     x_out;
    logic [Y_W-1:0]     y_out;
    logic               hit_out;
    logic [INDEX_W-1:0] block_index_out;
    logic [31:0]        best_t_out;
    logic [31:0]        ray_x_out;
    logic [31:0]        ray_y_out;
    logic [31:0]        ray_z_out;
    logic               sync_err_out;

    modport slave (
        input  valid_in, x_in, y_in, block_index_in, intersect_in, t_in,
               ray_x_in, ray_y_in, ray_z_in, ready_in,
        output ready_out, valid_out, x_out, y_out, hit_out, block_index_out,
               best_t_out, ray_x_out, ray_y_out, ray_z_out, sync_err_out
    );

    modport master (
        output valid_in, x_in, y_in, block_index_in, intersect_in, t_in,
               ray_x_in, ray_y_in, ray_z_in, ready_in,
        input  ready_out, valid_out, x_out, y_out, hit_out, block_index_out,
               best_t_out, ray_x_out, ray_y_out, ray_z_out, sync_err_out
    );
endinterface

// File: rtl/nearest_block_resolver.sv
// Reduces NUM_BLOCKS intersection beats per pixel to the nearest hit and queues it in a FWFT FIFO.
// Optional macro SABER_PRIORITY_EN: a candidate on block SABER_INDEX wins its group regardless of t.
module nearest_block_resolver #(
    parameter int NUM_BLOCKS  = 13,
    parameter int INDEX_W     = 4,
    parameter int X_W         = 11,
    parameter int Y_W         = 10,
    parameter int OUT_DEPTH   = 4,
    parameter int SABER_INDEX = 12
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    nearest_block_resolver_if.slave  bus
);
    localparam int BEAT_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int PTR_W  = $clog2(OUT_DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BLOCKS - 1);
    localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W+1)'(OUT_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [31:0]       NO_HIT_T  = 32'h7F80_0000;
`ifdef SABER_PRIORITY_EN
    localparam bit SABER_EN = 1'b1;
`else
    localparam bit SABER_EN = 1'b0;
`endif

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic               hit;
        logic [INDEX_W-1:0] idx;
        logic [31:0]        t;
        logic [31:0]        rx;
        logic [31:0]        ry;
        logic [31:0]        rz;
    } result_t;

    logic [BEAT_W-1:0] beat_q, beat_d;
    result_t           acc_q, acc_d, res_d, head;
    logic              saber_q, saber_d;
    logic              err_q, err_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    result_t           fifo_mem_q [OUT_DEPTH];

    logic accept, is_first, is_last, is_nan, cand, cand_saber, take, push, pop;

    // Stall only the last beat, and only on registered FIFO occupancy.
    assign bus.ready_out = rst_in && ((beat_q != LAST_BEAT) || (count_q < CNT_FULL));

    always_comb begin
        accept     = bus.valid_in && bus.ready_out;
        is_first   = (beat_q == '0);
        is_last    = (beat_q == LAST_BEAT);
        is_nan     = (bus.t_in[30:23] == 8'hFF) && (bus.t_in[22:0] != '0);
        cand       = bus.intersect_in && !bus.t_in[31] && !is_nan;
        cand_saber = SABER_EN && cand && (bus.block_index_in == INDEX_W'(SABER_INDEX));
        take       = 1'b0;
        res_d      = acc_q;
        saber_d    = saber_q;

        if (is_first) begin
            res_d.x   = bus.x_in;
            res_d.y   = bus.y_in;
            res_d.rx  = bus.ray_x_in;
            res_d.ry  = bus.ray_y_in;
            res_d.rz  = bus.ray_z_in;
            res_d.hit = cand;
            res_d.idx = cand ? bus.block_index_in : '0;
            res_d.t   = cand ? bus.t_in : NO_HIT_T;
            saber_d   = cand_saber;
        end else begin
            // Sign bit is known clear for candidates, so the magnitude compare orders floats.
            take = cand && ((cand_saber && !saber_q) ||
                            ((cand_saber == saber_q) &&
                             (!acc_q.hit || (bus.t_in[30:0] < acc_q.t[30:0]))));
            if (take) begin
                res_d.hit = 1'b1;
                res_d.idx = bus.block_index_in;
                res_d.t   = bus.t_in;
                saber_d   = cand_saber;
            end
        end

        beat_d = beat_q;
        acc_d  = acc_q;
        if (accept) begin
            beat_d = is_last ? '0 : beat_q + BEAT_W'(1);
            acc_d  = res_d;
        end
        if (!accept) saber_d = saber_q;

        err_d = err_q || (accept && !is_first &&
                          ((bus.x_in != acc_q.x) || (bus.y_in != acc_q.y)));

        push     = accept && is_last;
        pop      = (count_q != '0) && bus.ready_in;
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            beat_q   <= '0;
            acc_q    <= '0;
            saber_q  <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            beat_q   <= beat_d;
            acc_q    <= acc_d;
            saber_q  <= saber_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is unreset; the output mux below masks stale entries.
    always_ff @(posedge clk_in) begin
        if (push) fifo_mem_q[wr_ptr_q] <= res_d;
    end

    assign head = (count_q != '0) ? fifo_mem_q[rd_ptr_q] : '0;

    assign bus.valid_out       = (count_q != '0);
    assign bus.x_out           = head.x;
    assign bus.y_out           = head.y;
    assign bus.hit_out         = head.hit;
    assign bus.block_index_out = head.idx;
    assign bus.best_t_out      = head.t;
    assign bus.ray_x_out       = head.rx;
    assign bus.ray_y_out       = head.ry;
    assign bus.ray_z_out       = head.rz;
    assign bus.sync_err_out    = err_q;
endmodule

// File: tb/tb_nearest_block_resolver.sv
// Directed bench for nearest_block_resolver with NUM_BLOCKS=3, OUT_DEPTH=4.
// Honours SABER_PRIORITY_EN to pick the expected saber-group winner.
module tb_nearest_block_resolver;
    localparam int NB    = 3;
    localparam int IW    = 4;
    localparam int XW    = 11;
    localparam int YW    = 10;
    localparam int DEPTH = 4;

    localparam logic [31:0] F0_5  = 32'h3F00_0000;
    localparam logic [31:0] F1_0  = 32'h3F80_0000;
    localparam logic [31:0] F1_5  = 32'h3FC0_0000;
    localparam logic [31:0] F2_0  = 32'h4000_0000;
    localparam logic [31:0] F3_0  = 32'h4040_0000;
    localparam logic [31:0] F4_0  = 32'h4080_0000;
    localparam logic [31:0] FM1_0 = 32'hBF80_0000;
    localparam logic [31:0] FNEG0 = 32'h8000_0000;
    localparam logic [31:0] FNAN  = 32'h7FC0_0000;
    localparam logic [31:0] FINF  = 32'h7F80_0000;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    nearest_block_resolver_if #(.X_W(XW), .Y_W(YW), .INDEX_W(IW)) bus ();

    nearest_block_resolver #(
        .NUM_BLOCKS(NB), .INDEX_W(IW), .X_W(XW), .Y_W(YW),
        .OUT_DEPTH(DEPTH), .SABER_INDEX(12)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          hit;
        logic [IW-1:0] idx;
        logic [31:0]   t;
        logic [31:0]   rx;
        logic [31:0]   rz;
    } res_t;

    res_t got_q[$];
    int   errors = 0;
    int   checks = 0;
    logic st;
    logic st_last;
    time  t_start;

    always @(negedge clk_in) begin
        if (bus.valid_out && bus.ready_in)
            got_q.push_back('{bus.x_out, bus.y_out, bus.hit_out, bus.block_index_out,
                              bus.best_t_out, bus.ray_x_out, bus.ray_z_out});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [XW-1:0] x, input logic [YW-1:0] y,
                             input logic [IW-1:0] idx, input logic hit,
                             input logic [31:0] t, input int b, output logic stalled);
        int n;
        bus.valid_in       = 1'b1;
        bus.x_in           = x;
        bus.y_in           = y;
        bus.block_index_in = idx;
        bus.intersect_in   = hit;
        bus.t_in           = t;
        bus.ray_x_in       = 32'hA000_0000 | 32'(b);
        bus.ray_y_in       = 32'hB000_0000 | 32'(b);
        bus.ray_z_in       = 32'hC000_0000 | 32'(b);
        stalled = 1'b0;
        n = 0;
        @(negedge clk_in);
        while (!bus.ready_out && n < 200) begin
            stalled = 1'b1;
            n++;
            @(negedge clk_in);
        end
        if (!bus.ready_out) check("beat_timeout", 64'd0, 64'd1);
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_group(input logic [XW-1:0] x, input logic [YW-1:0] y,
                              input logic [IW-1:0] i0, input logic h0, input logic [31:0] t0,
                              input logic [IW-1:0] i1, input logic h1, input logic [31:0] t1,
                              input logic [IW-1:0] i2, input logic h2, input logic [31:0] t2,
                              output logic stalled_last);
        logic s;
        send_beat(x, y, i0, h0, t0, 0, s);
        send_beat(x, y, i1, h1, t1, 1, s);
        send_beat(x, y, i2, h2, t2, 2, stalled_last);
    endtask

    task automatic idle();
        bus.valid_in     = 1'b0;
        bus.intersect_in = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [XW-1:0] x, input logic [YW-1:0] y,
                                input logic hit, input logic [IW-1:0] idx, input logic [31:0] t);
        res_t r;
        int   n = 0;
        while (got_q.size() == 0 && n < 50) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        if (got_q.size() == 0) begin
            check({tag, "_missing"}, 64'd0, 64'd1);
        end else begin
            r = got_q.pop_front();
            $display("result %s: x=%0d y=%0d hit=%0d idx=%0d t=%h", tag, r.x, r.y, r.hit, r.idx, r.t);
            check({tag, "_x"},   64'(r.x),   64'(x));
            check({tag, "_y"},   64'(r.y),   64'(y));
            check({tag, "_hit"}, 64'(r.hit), 64'(hit));
            check({tag, "_idx"}, 64'(r.idx), 64'(idx));
            check({tag, "_t"},   64'(r.t),   64'(t));
            check({tag, "_rx"},  64'(r.rx),  64'h0000_0000_A000_0000);
            check({tag, "_rz"},  64'(r.rz),  64'h0000_0000_C000_0000);
        end
    endtask

    initial begin
        bus.valid_in = 1'b0; bus.ready_in = 1'b1; bus.x_in = '0; bus.y_in = '0;
        bus.block_index_in = '0; bus.intersect_in = 1'b0; bus.t_in = '0;
        bus.ray_x_in = '0; bus.ray_y_in = '0; bus.ray_z_in = '0;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_ready_out", 64'(bus.ready_out), 64'd0);
        check("rst_valid_out", 64'(bus.valid_out), 64'd0);
        check("rst_sync_err",  64'(bus.sync_err_out), 64'd0);
        check("rst_best_t",    64'(bus.best_t_out), 64'd0);
        check("rst_x_out",     64'(bus.x_out), 64'd0);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("ready_after_rst", 64'(bus.ready_out), 64'd1);

        // Basic nearest, full-rate beats, one-cycle result latency
        t_start = $time;
        send_group(5, 7, 0, 1, F2_0, 1, 1, F1_0, 2, 0, F0_5, st);
        check("basic_cycles", 64'($time - t_start), 64'd30);
        check("basic_latency_valid", 64'(bus.valid_out), 64'd1);
        idle();
        check_result("basic", 5, 7, 1, 1, F1_0);

        // Negative t rejected
        send_group(6, 8, 0, 0, F1_0, 1, 1, FM1_0, 2, 0, F2_0, st);
        idle();
        check_result("neg_t", 6, 8, 0, 0, FINF);

        // NaN and -0 rejected
        send_group(9, 9, 3, 1, FNAN, 4, 1, FNEG0, 5, 0, F1_0, st);
        idle();
        check_result("nan_negzero", 9, 9, 0, 0, FINF);

        // Tie: earlier beat wins
        send_group(11, 2, 0, 0, F1_0, 1, 1, F3_0, 2, 1, F3_0, st);
        idle();
        check_result("tie", 11, 2, 1, 1, F3_0);

        // Backpressure: four groups fill the FIFO, the fifth stalls on its last beat
        bus.ready_in = 1'b0;
        for (int g = 0; g < 4; g++) begin
            send_group(XW'(10 + g), 1,
                       4, 1, (g % 3 == 0) ? F1_0 : F2_0,
                       5, 1, (g % 3 == 1) ? F1_0 : F2_0,
                       6, 1, (g % 3 == 2) ? F1_0 : F2_0, st);
            check($sformatf("bp_nostall_g%0d", g), 64'(st), 64'd0);
        end
        fork
            send_group(14, 1, 4, 1, F2_0, 5, 1, F1_0, 6, 1, F2_0, st_last);
            begin
                repeat (8) @(negedge clk_in);
                check("bp_ready_low", 64'(bus.ready_out), 64'd0);
                check("bp_valid_held", 64'(bus.valid_out), 64'd1);
                check("bp_head_x", 64'(bus.x_out), 64'd10);
                check("bp_nothing_popped", 64'(got_q.size()), 64'd0);
                @(posedge clk_in);
                #1;
                bus.ready_in = 1'b1;
            end
        join
        check("bp_stalled_5th", 64'(st_last), 64'd1);
        idle();
        for (int g = 0; g < 5; g++)
            check_result($sformatf("bp_g%0d", g), XW'(10 + g), 1, 1, IW'(4 + g % 3), F1_0);
        repeat (5) @(posedge clk_in);
        #1;
        check("bp_no_dup", 64'(got_q.size()), 64'd0);

        // Framing error: x changes on beat 1
        send_beat(20, 3, 0, 0, F1_0, 0, st);
        send_beat(21, 3, 1, 1, F2_0, 1, st);
        send_beat(20, 3, 2, 0, F1_0, 2, st);
        idle();
        check("frame_err_set", 64'(bus.sync_err_out), 64'd1);
        check_result("frame", 20, 3, 1, 1, F2_0);
        send_group(22, 4, 0, 1, F0_5, 1, 0, F0_5, 2, 0, F0_5, st);
        idle();
        check("frame_err_sticky", 64'(bus.sync_err_out), 64'd1);
        check_result("after_frame", 22, 4, 1, 0, F0_5);

        // Reset mid-group with a result still queued
        bus.ready_in = 1'b0;
        send_group(25, 5, 0, 1, F1_0, 1, 0, F1_0, 2, 0, F1_0, st);
        send_beat(30, 5, 0, 1, F0_5, 0, st);
        send_beat(30, 5, 1, 1, F0_5, 1, st);
        idle();
        rst_in = 1'b0;
        #1;
        check("rst_mid_ready_low", 64'(bus.ready_out), 64'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        check("rst_mid_fifo_empty", 64'(bus.valid_out), 64'd0);
        check("rst_mid_err_clear", 64'(bus.sync_err_out), 64'd0);
        check("rst_mid_t_zero", 64'(bus.best_t_out), 64'd0);
        got_q.delete();
        bus.ready_in = 1'b1;
        send_group(31, 6, 0, 1, F2_0, 1, 0, F0_5, 2, 1, F1_5, st);
        idle();
        check_result("post_rst", 31, 6, 1, 2, F1_5);
        repeat (5) @(posedge clk_in);
        #1;
        check("post_rst_single", 64'(got_q.size()), 64'd0);

        // Saber priority
        send_group(40, 8, 3, 1, F0_5, 12, 1, F4_0, 5, 0, F1_0, st);
        idle();
`ifdef SABER_PRIORITY_EN
        check_result("saber", 40, 8, 1, 12, F4_0);
`else
        check_result("saber", 40, 8, 1, 3, F0_5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
